// File: rtl/pe_mac_acc_if.sv
// Bus bundle for the pe_mac_acc processing element. The feeder and collector
// side uses the master modport, and the PE uses the slave modport.
interface pe_mac_acc_if #(
  parameter int DATA_WIDTH   = 8,
  parameter int WEIGHT_WIDTH = 8,
  parameter int PSUM_WIDTH   = 24,
  parameter int CNT_WIDTH    = 8
);
  logic                           i_mode;
  logic [CNT_WIDTH-1:0]           i_acc_len;
  logic                           i_clear;
  logic signed [DATA_WIDTH-1:0]   i_data;
  logic                           i_data_vld;
  logic signed [WEIGHT_WIDTH-1:0] i_weight;
  logic                           i_weight_vld;
  logic signed [PSUM_WIDTH-1:0]   i_psum;
  logic                           i_psum_vld;
  logic signed [PSUM_WIDTH-1:0]   o_psum;
  logic                           o_psum_vld;
  logic                           o_busy;
  logic                           o_ovf;

  modport master (
    output i_mode, i_acc_len, i_clear, i_data, i_data_vld,
           i_weight, i_weight_vld, i_psum, i_psum_vld,
    input  o_psum, o_psum_vld, o_busy, o_ovf
  );

  modport slave (
    input  i_mode, i_acc_len, i_clear, i_data, i_data_vld,
           i_weight, i_weight_vld, i_psum, i_psum_vld,
    output o_psum, o_psum_vld, o_busy, o_ovf
  );
endinterface

// File: rtl/pe_mac_acc.sv
// Pipelined signed MAC processing element. It has a chain mode and a
// local-accumulate mode, and its saturating adder drives a sticky overflow flag.
module pe_mac_acc #(
  parameter int DATA_WIDTH   = 8,
  parameter int WEIGHT_WIDTH = 8,
  parameter int PSUM_WIDTH   = 24,
  parameter int MUL_LAT      = 4,
  parameter int CNT_WIDTH    = 8
) (
  input logic         clk,
  input logic         rst,
  pe_mac_acc_if.slave bus
);
  localparam int PROD_WIDTH = DATA_WIDTH + WEIGHT_WIDTH;
  localparam int SUM_WIDTH  = PSUM_WIDTH + 1;
  localparam logic signed [PSUM_WIDTH-1:0] PSUM_MAX = {1'b0, {(PSUM_WIDTH-1){1'b1}}};
  localparam logic signed [PSUM_WIDTH-1:0] PSUM_MIN = {1'b1, {(PSUM_WIDTH-1){1'b0}}};

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t                         state, state_next;
  logic signed [DATA_WIDTH-1:0]   data_reg;
  logic signed [WEIGHT_WIDTH-1:0] weight_reg;
  logic                           issue_vld;
  logic signed [PROD_WIDTH-1:0]   prod_pipe [MUL_LAT];
  logic [MUL_LAT-1:0]             vld_pipe;
  logic signed [PSUM_WIDTH-1:0]   acc, acc_next, psum_reg;
  logic [CNT_WIDTH-1:0]           cnt, cnt_next, cnt_inc, len_reg, len_next, len_eff;
  logic                           out_vld, emit, ovf, ovf_next, prod_vld, sum_clamped;
  logic signed [PSUM_WIDTH-1:0]   prod_ext, addend, sum_sat;
  logic signed [SUM_WIDTH-1:0]    sum_wide;

  // Operands stay in their registers until reloaded. A clear does not zero them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_reg   <= '0;
      weight_reg <= '0;
      issue_vld  <= 1'b0;
    end else begin
      if (bus.i_data_vld)   data_reg   <= bus.i_data;
      if (bus.i_weight_vld) weight_reg <= bus.i_weight;
      issue_vld <= bus.i_data_vld & ~bus.i_clear;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MUL_LAT; i++) prod_pipe[i] <= '0;
      vld_pipe <= '0;
    end else begin
      prod_pipe[0] <= PROD_WIDTH'(data_reg) * PROD_WIDTH'(weight_reg);
      vld_pipe[0]  <= issue_vld & ~bus.i_clear;
      for (int i = 1; i < MUL_LAT; i++) begin
        prod_pipe[i] <= prod_pipe[i-1];
        vld_pipe[i]  <= vld_pipe[i-1] & ~bus.i_clear;
      end
    end
  end

  assign prod_vld = vld_pipe[MUL_LAT-1];
  assign prod_ext = PSUM_WIDTH'(prod_pipe[MUL_LAT-1]);
  assign len_eff  = (bus.i_acc_len == '0) ? CNT_WIDTH'(1) : bus.i_acc_len;
  assign cnt_inc  = cnt + CNT_WIDTH'(1);

  // A window opens with addend 0. After that, addend is the running accumulator.
  always_comb begin
    addend = '0;
    if (bus.i_mode) begin
      if (state == ACCUM) addend = acc;
    end else if (bus.i_psum_vld) begin
      addend = bus.i_psum;
    end
    sum_wide    = SUM_WIDTH'(addend) + SUM_WIDTH'(prod_ext);
    sum_clamped = sum_wide[PSUM_WIDTH] != sum_wide[PSUM_WIDTH-1];
    sum_sat     = sum_wide[PSUM_WIDTH-1:0];
    if (sum_clamped) sum_sat = sum_wide[PSUM_WIDTH] ? PSUM_MIN : PSUM_MAX;
  end

  always_comb begin
    state_next = state;
    acc_next   = acc;
    cnt_next   = cnt;
    len_next   = len_reg;
    ovf_next   = ovf;
    emit       = 1'b0;
    if (prod_vld) begin
      if (sum_clamped) ovf_next = 1'b1;
      if (!bus.i_mode) begin
        emit = 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (len_eff == CNT_WIDTH'(1)) begin
              emit = 1'b1;
            end else begin
              acc_next   = sum_sat;
              cnt_next   = CNT_WIDTH'(1);
              len_next   = len_eff;
              state_next = ACCUM;
            end
          end
          ACCUM: begin
            if (cnt_inc == len_reg) begin
              emit       = 1'b1;
              acc_next   = '0;
              cnt_next   = '0;
              state_next = IDLE;
            end else begin
              acc_next = sum_sat;
              cnt_next = cnt_inc;
            end
          end
          default: state_next = IDLE;
        endcase
      end
    end
    if (bus.i_clear) begin
      state_next = IDLE;
      acc_next   = '0;
      cnt_next   = '0;
      ovf_next   = 1'b0;
      emit       = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      acc      <= '0;
      cnt      <= '0;
      len_reg  <= '0;
      ovf      <= 1'b0;
      out_vld  <= 1'b0;
      psum_reg <= '0;
    end else begin
      state   <= state_next;
      acc     <= acc_next;
      cnt     <= cnt_next;
      len_reg <= len_next;
      ovf     <= ovf_next;
      out_vld <= emit;
      if (emit) psum_reg <= sum_sat;
    end
  end

  assign bus.o_psum     = psum_reg;
  assign bus.o_psum_vld = out_vld;
  assign bus.o_ovf      = ovf;
  assign bus.o_busy     = issue_vld | (|vld_pipe) | (state == ACCUM) | out_vld;
endmodule

// File: tb/tb_pe_mac_acc.sv
// Self-checking bench for pe_mac_acc. PSUM_WIDTH is 16, so saturation is reachable with 8-bit operands.
// A scoreboard queue holds the expected result and the strobe cycle for every issue.
module tb_pe_mac_acc;
  localparam int DW = 8;
  localparam int WW = 8;
  localparam int PW = 16;
  localparam int ML = 4;
  localparam int CW = 8;
  localparam int NV = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  typedef struct { int psum; int cyc; } exp_t;
  typedef struct { int d; int w; int ps; bit pv; int exp_psum; } vec_t;
  exp_t sb[$];
  vec_t vecs[NV];

  pe_mac_acc_if #(.DATA_WIDTH(DW), .WEIGHT_WIDTH(WW), .PSUM_WIDTH(PW), .CNT_WIDTH(CW)) bus ();

  pe_mac_acc #(
    .DATA_WIDTH(DW), .WEIGHT_WIDTH(WW), .PSUM_WIDTH(PW), .MUL_LAT(ML), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input bit dv, input int d, input bit wv, input int w,
                                input bit pv, input int ps, input bit clr);
    @(negedge clk);
    bus.i_data_vld   = dv;
    bus.i_data       = DW'(d);
    bus.i_weight_vld = wv;
    bus.i_weight     = WW'(w);
    bus.i_psum_vld   = pv;
    bus.i_psum       = PW'(ps);
    bus.i_clear      = clr;
  endtask

  task automatic idle();
    apply_stimulus(1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0);
  endtask

  task automatic expect_result(input int v, input int c);
    sb.push_back('{psum: v, cyc: c});
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    idle();
    while ((sb.size() != 0 || bus.o_busy) && n < 60) begin
      idle();
      n++;
    end
    if (n >= 60) begin
      tests++;
      fails++;
      $display("[TB] FAIL idle_timeout: got %0d pending results, expected 0", sb.size());
      sb.delete();
    end
  endtask

  // The issue happens in cycle t. i_psum is driven in the product cycle t+5, and the strobe is expected at t+6.
  task automatic chain_one(input int d, input int w, input bit wv, input int ps, input bit pv,
                           input int exp);
    int t;
    apply_stimulus(1'b1, d, wv, w, 1'b0, 0, 1'b0);
    t = cyc;
    expect_result(exp, t + ML + 2);
    repeat (ML) idle();
    apply_stimulus(1'b0, 0, 1'b0, 0, pv, ps, 1'b0);
    idle();
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (bus.o_psum_vld) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("[TB] FAIL unexpected_strobe: got psum %0d at cycle %0d, expected no strobe",
                 bus.o_psum, cyc);
      end else begin
        e = sb.pop_front();
        check_output("strobe_psum", int'(bus.o_psum), e.psum);
        check_output("strobe_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before 200us");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int t, n, di, wi, psi;
    bit pvi, dvi;

    vecs[0] = '{d: 5,    w: 3,    ps: 100,    pv: 1'b1, exp_psum: 115};
    vecs[1] = '{d: -128, w: 127,  ps: 555,    pv: 1'b0, exp_psum: -16256};
    vecs[2] = '{d: 127,  w: 127,  ps: -129,   pv: 1'b1, exp_psum: 16000};
    vecs[3] = '{d: -1,   w: -1,   ps: 0,      pv: 1'b1, exp_psum: 1};
    vecs[4] = '{d: 0,    w: -77,  ps: -32768, pv: 1'b1, exp_psum: -32768};
    vecs[5] = '{d: 10,   w: -10,  ps: 32767,  pv: 1'b1, exp_psum: 32667};
    vecs[6] = '{d: -128, w: -128, ps: -16384, pv: 1'b1, exp_psum: 0};
    vecs[7] = '{d: 7,    w: 8,    ps: 1000,   pv: 1'b0, exp_psum: 56};

    bus.i_mode = 1'b0; bus.i_acc_len = 8'd1; bus.i_clear = 1'b0;
    bus.i_data = '0; bus.i_data_vld = 1'b0; bus.i_weight = '0; bus.i_weight_vld = 1'b0;
    bus.i_psum = '0; bus.i_psum_vld = 1'b0;

    #12;
    check_output("reset_psum", int'(bus.o_psum), 0);
    check_output("reset_vld", int'(bus.o_psum_vld), 0);
    check_output("reset_busy", int'(bus.o_busy), 0);
    check_output("reset_ovf", int'(bus.o_ovf), 0);
    @(negedge clk);
    rst = 1'b0;

    // Chain mode. The weight is loaded alone and stays stationary for the issue.
    apply_stimulus(1'b0, 0, 1'b1, 3, 1'b0, 0, 1'b0);
    chain_one(5, 0, 1'b0, 100, 1'b1, 115);
    idle();
    check_output("chain_vld_one_cycle", int'(bus.o_psum_vld), 0);
    check_output("chain_psum_hold", int'(bus.o_psum), 115);
    wait_idle();

    // Back-to-back chain vectors, issued one per cycle.
    for (int c = 0; c < NV + ML + 1; c++) begin
      dvi = 1'b0; di = 0; wi = 0; pvi = 1'b0; psi = 0;
      if (c < NV) begin
        dvi = 1'b1; di = vecs[c].d; wi = vecs[c].w;
      end
      if (c >= ML + 1) begin
        pvi = vecs[c-ML-1].pv; psi = vecs[c-ML-1].ps;
      end
      apply_stimulus(dvi, di, dvi, wi, pvi, psi, 1'b0);
      if (c < NV) expect_result(vecs[c].exp_psum, cyc + ML + 2);
    end
    wait_idle();
    check_output("table_ovf_clear", int'(bus.o_ovf), 0);

    // Accumulate L=4 with weight 2 and data 1..4. One strobe of 20 is expected at t+9.
    bus.i_mode = 1'b1; bus.i_acc_len = 8'd4;
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(1'b1, i + 1, i == 0, 2, 1'b0, 0, 1'b0);
      if (i == 0) t = cyc;
    end
    expect_result(20, t + 9);
    n = 0;
    while (cyc < t + 9 && n < 20) begin
      idle();
      n++;
    end
    check_output("accum_busy_at_strobe", int'(bus.o_busy), 1);
    idle();
    check_output("accum_busy_after", int'(bus.o_busy), 0);
    wait_idle();

    // With L=1, every product is emitted directly.
    bus.i_acc_len = 8'd1;
    apply_stimulus(1'b1, 5, 1'b1, 2, 1'b0, 0, 1'b0); t = cyc;
    apply_stimulus(1'b1, -6, 1'b0, 0, 1'b0, 0, 1'b0);
    apply_stimulus(1'b1, 7, 1'b0, 0, 1'b0, 0, 1'b0);
    expect_result(10, t + 6); expect_result(-12, t + 7); expect_result(14, t + 8);
    wait_idle();
    // L=0 behaves like L=1.
    bus.i_acc_len = 8'd0;
    apply_stimulus(1'b1, -3, 1'b1, 9, 1'b0, 0, 1'b0);
    expect_result(-27, cyc + 6);
    wait_idle();

    // Back-to-back L=2 windows.
    bus.i_acc_len = 8'd2;
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(1'b1, i + 1, i == 0, 2, 1'b0, 0, 1'b0);
      if (i == 0) t = cyc;
    end
    expect_result(6, t + 7); expect_result(14, t + 9);
    wait_idle();
    check_output("b2b_ovf", int'(bus.o_ovf), 0);

    // Positive saturation with L=3. The sticky flag holds until a clear.
    bus.i_acc_len = 8'd3;
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1'b1, 127, i == 0, 127, 1'b0, 0, 1'b0);
      if (i == 0) t = cyc;
    end
    expect_result(32767, t + 8);
    wait_idle();
    check_output("sat_ovf_set", int'(bus.o_ovf), 1);
    repeat (3) idle();
    check_output("sat_ovf_sticky", int'(bus.o_ovf), 1);
    apply_stimulus(1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b1);
    idle();
    check_output("sat_ovf_cleared", int'(bus.o_ovf), 0);
    check_output("clear_keeps_psum", int'(bus.o_psum), 32767);

    // A saturated accumulator keeps going from its clamped value: 32767 - 16256 = 16511.
    bus.i_acc_len = 8'd4;
    apply_stimulus(1'b1, 127, 1'b1, 127, 1'b0, 0, 1'b0); t = cyc;
    apply_stimulus(1'b1, 127, 1'b0, 0, 1'b0, 0, 1'b0);
    apply_stimulus(1'b1, 127, 1'b0, 0, 1'b0, 0, 1'b0);
    apply_stimulus(1'b1, -128, 1'b0, 0, 1'b0, 0, 1'b0);
    expect_result(16511, t + 9);
    wait_idle();
    check_output("sat_continue_ovf", int'(bus.o_ovf), 1);
    apply_stimulus(1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b1);

    // Clear in the middle of a window. The aborted window must produce no strobe.
    apply_stimulus(1'b1, 5, 1'b1, 1, 1'b0, 0, 1'b0);
    apply_stimulus(1'b1, 6, 1'b0, 0, 1'b0, 0, 1'b0);
    apply_stimulus(1'b1, 7, 1'b0, 0, 1'b0, 0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(1'b1, 1, 1'b0, 0, 1'b0, 0, 1'b0);
      if (i == 0) t = cyc;
    end
    expect_result(4, t + 9);
    wait_idle();
    check_output("clear_window_ovf", int'(bus.o_ovf), 0);

    // Negative saturation in chain mode. This also sets the flag before the reset test.
    bus.i_mode = 1'b0;
    chain_one(-128, 127, 1'b1, -20000, 1'b1, -32768);
    wait_idle();
    check_output("chain_neg_sat_ovf", int'(bus.o_ovf), 1);

    // Asynchronous reset between clock edges while three issues are in flight.
    apply_stimulus(1'b1, 1, 1'b1, 1, 1'b0, 0, 1'b0);
    apply_stimulus(1'b1, 2, 1'b0, 0, 1'b0, 0, 1'b0);
    apply_stimulus(1'b1, 3, 1'b0, 0, 1'b0, 0, 1'b0);
    #2 rst = 1'b1;
    #1;
    check_output("async_rst_psum", int'(bus.o_psum), 0);
    check_output("async_rst_vld", int'(bus.o_psum_vld), 0);
    check_output("async_rst_busy", int'(bus.o_busy), 0);
    check_output("async_rst_ovf", int'(bus.o_ovf), 0);
    bus.i_data_vld = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) idle();
    chain_one(9, -4, 1'b1, 50, 1'b1, 14);
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
